// File: rtl/osd_spi_sched_if.sv
// Requester-side bundle of osd_spi_sched: requests, command/length/payload inputs,
// and the one-hot grant, byte-consumed and done strobes returned to each requester.
interface osd_spi_sched_if;
  logic [1:0] req;
  logic [7:0] r0_cmd;
  logic [7:0] r1_cmd;
  logic [8:0] r0_len;
  logic [8:0] r1_len;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [1:0] gnt;
  logic [1:0] byte_rd;
  logic [1:0] done;

  modport master (
    output req, r0_cmd, r1_cmd, r0_len, r1_len, d0, d1,
    input  gnt, byte_rd, done
  );

  modport slave (
    input  req, r0_cmd, r1_cmd, r0_len, r1_len, d0, d1,
    output gnt, byte_rd, done
  );
endinterface

// File: rtl/osd_spi_sched.sv
// Round-robin scheduler of two requesters onto the OSD SPI command port (mode 0, MSB first).
// OSD_SCHED_ENSHADOW_EN adds osd_en_state and skips 0x40-class commands that would not change it.
module osd_spi_sched #(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 2
) (
  input  logic           clk_sys,
  input  logic           reset,
  osd_spi_sched_if.slave host,
  output logic           busy,
  output logic           SPI_SCK,
  output logic           SPI_SS3,
  output logic           SPI_DI
`ifdef OSD_SCHED_ENSHADOW_EN
  ,
  output logic           osd_en_state
`endif
);
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_END, ST_SKIP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] div_cnt;
  logic [15:0] gap_cnt;
  logic [2:0]  bit_cnt;
  logic [8:0]  remain;
  logic [7:0]  sreg;
  logic        sel;
  logic        rr;
  logic        half_end;
  logic        win;
  logic        grant;
  logic        fall;
  logic        load;
  logic        finish;
  logic        skip;
  logic [7:0]  win_cmd;
  logic [8:0]  win_len;

  assign half_end = (div_cnt == 16'(CLK_DIV - 1));
  // rr holds the last granted requester; on contention the other one wins
  assign win      = (host.req == 2'b11) ? ~rr : host.req[1];
  assign win_cmd  = win ? host.r1_cmd : host.r0_cmd;
  assign win_len  = win ? host.r1_len : host.r0_len;
  assign busy     = (state != ST_IDLE);
  assign SPI_DI   = sreg[7];

`ifdef OSD_SCHED_ENSHADOW_EN
  logic [7:0] cmd_l;
  assign skip = (win_cmd[7:3] == 5'b01000) && (win_cmd[0] == osd_en_state);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    fall      = 1'b0;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((|host.req) && (gap_cnt >= 16'(GAP))) begin
          grant     = 1'b1;
          state_nxt = skip ? ST_SKIP : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (half_end && SPI_SCK) begin
          fall = 1'b1;
          if (bit_cnt == 3'd0) begin
            if (remain != 9'd0) load = 1'b1;
            else                state_nxt = ST_END;
          end
        end
      end
      ST_END: begin
        if (half_end) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt      <= '0;
      gap_cnt      <= 16'(GAP);
      bit_cnt      <= '0;
      remain       <= '0;
      sreg         <= '0;
      sel          <= 1'b0;
      rr           <= 1'b1;
      host.gnt     <= '0;
      host.byte_rd <= '0;
      host.done    <= '0;
      SPI_SCK      <= 1'b0;
      SPI_SS3      <= 1'b1;
    end else begin
      host.byte_rd <= '0;
      host.done    <= '0;
      if ((state == ST_IDLE) && (gap_cnt < 16'(GAP))) gap_cnt <= gap_cnt + 16'd1;
      if ((state == ST_SHIFT) || (state == ST_END)) div_cnt <= half_end ? '0 : div_cnt + 16'd1;
      if ((state == ST_SHIFT) && half_end) SPI_SCK <= ~SPI_SCK;
      if (grant) begin
        sel      <= win;
        host.gnt <= win ? 2'b10 : 2'b01;
        sreg     <= win_cmd;
        remain   <= (win_len > 9'd256) ? 9'd256 : win_len;
        bit_cnt  <= 3'd7;
        div_cnt  <= '0;
        SPI_SS3  <= skip;
      end
      // bit_cnt wraps 0 -> 7 on its own when the next byte is loaded
      if (fall) begin
        sreg    <= {sreg[6:0], 1'b0};
        bit_cnt <= bit_cnt - 3'd1;
      end
      if (load) begin
        sreg         <= sel ? host.d1 : host.d0;
        remain       <= remain - 9'd1;
        host.byte_rd <= sel ? 2'b10 : 2'b01;
      end
      if (finish) begin
        SPI_SS3   <= 1'b1;
        host.gnt  <= '0;
        host.done <= sel ? 2'b10 : 2'b01;
        rr        <= sel;
        gap_cnt   <= '0;
      end
    end
  end

`ifdef OSD_SCHED_ENSHADOW_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cmd_l        <= '0;
      osd_en_state <= 1'b0;
    end else begin
      if (grant) cmd_l <= win_cmd;
      if (finish && (cmd_l[7:3] == 5'b01000)) osd_en_state <= cmd_l[0];
    end
  end
`endif
endmodule

// File: tb/tb_osd_spi_sched.sv
// Directed bench for osd_spi_sched with CLK_DIV=2, GAP=2; a negedge monitor collects SPI activity.
`timescale 1ns/1ps
module tb_osd_spi_sched;
  localparam int CD = 2;
  localparam int GP = 2;

  logic clk_sys = 1'b0;
  logic reset;
  logic busy, sck, ss3, di;
`ifdef OSD_SCHED_ENSHADOW_EN
  logic osd_en_state;
`endif

  osd_spi_sched_if bus();

  osd_spi_sched #(.CLK_DIV(CD), .GAP(GP)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .host    (bus.slave),
    .busy    (busy),
    .SPI_SCK (sck),
    .SPI_SS3 (ss3),
    .SPI_DI  (di)
`ifdef OSD_SCHED_ENSHADOW_EN
    ,
    .osd_en_state (osd_en_state)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int n_run = 0;
  int n_fail = 0;
  logic clr = 1'b1;

  // payload sources: advance on each consumed byte
  logic [7:0] pay0, pay1;
  always @(posedge clk_sys) begin
    if (clr) begin
      pay0 <= 8'h10;
      pay1 <= 8'h00;
    end else begin
      if (bus.byte_rd[0]) pay0 <= pay0 + 8'd1;
      if (bus.byte_rd[1]) pay1 <= pay1 + 8'd1;
    end
  end
  assign bus.d0 = pay0;
  assign bus.d1 = pay1;

  int cyc, rises, falls, low_run, low_last, fall_cyc, brd0, brd1, done0, done1;
  int gnt_both, di_bad, done_bad, hi_run, min_high, have_txn, g_cyc, d_cyc, last_di_cyc;
  logic bits[$];
  int brd_off[$];
  int order[$];
  logic p_sck, p_ss3, p_di;
  logic [1:0] p_gnt;

  always @(negedge clk_sys) begin
    if (clr) begin
      cyc = 0; rises = 0; falls = 0; low_run = 0; low_last = 0; fall_cyc = 0;
      brd0 = 0; brd1 = 0; done0 = 0; done1 = 0; gnt_both = 0; di_bad = 0; done_bad = 0;
      hi_run = 0; min_high = 9999; have_txn = 0; g_cyc = 0; d_cyc = 0; last_di_cyc = 0;
      bits.delete(); brd_off.delete(); order.delete();
    end else begin
      cyc++;
      if (di !== p_di) last_di_cyc = cyc;
      if (!p_sck && sck) begin
        rises++;
        bits.push_back(di);
        if (cyc - last_di_cyc < CD) di_bad++;
      end
      if (p_ss3 && !ss3) begin
        falls++;
        fall_cyc = cyc;
        low_run = 0;
        if (have_txn != 0 && hi_run < min_high) min_high = hi_run;
      end
      if (!p_ss3 && ss3) begin
        low_last = low_run;
        have_txn = 1;
        hi_run = 0;
      end
      if (!ss3) low_run++;
      else if (have_txn != 0) hi_run++;
      if (bus.byte_rd[0]) brd0++;
      if (bus.byte_rd[1]) begin brd1++; brd_off.push_back(cyc - fall_cyc); end
      if (bus.done[0]) begin done0++; order.push_back(0); end
      if (bus.done[1]) begin done1++; order.push_back(1); end
      if (bus.done != 2'b00) begin
        d_cyc = cyc;
        if (!(!p_ss3 && ss3)) done_bad++;
      end
      if (p_gnt == 2'b00 && bus.gnt != 2'b00) g_cyc = cyc;
      if (bus.gnt == 2'b11) gnt_both++;
    end
    p_sck = sck; p_ss3 = ss3; p_di = di; p_gnt = bus.gnt;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic start_scn();
    reset = 1'b1; clr = 1'b1; bus.req = 2'b00;
    repeat (2) nclk();
    reset = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int k = 0;
    while ((done0 + done1) < n && k < budget) begin nclk(); k++; end
    chk(tag, done0 + done1, n);
  endtask

  function automatic logic [7:0] get_byte(input int idx);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++)
      b = {b[6:0], (idx * 8 + i < bits.size()) ? bits[idx * 8 + i] : 1'b0};
    return b;
  endfunction

  initial begin
    int errs_d, errs_t, k;
    reset = 1'b1; bus.req = 2'b00;
    bus.r0_cmd = 8'h00; bus.r1_cmd = 8'h00; bus.r0_len = 9'd0; bus.r1_len = 9'd0;
    repeat (3) nclk();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_byte_rd", bus.byte_rd, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sck", sck, 0);
    chk("rst_ss3", ss3, 1);
    chk("rst_di", di, 0);

    // single 0x41, no payload
    start_scn();
    bus.r0_cmd = 8'h41; bus.r0_len = 9'd0; bus.req = 2'b01;
    wait_dones(1, 200, "s1_done");
    bus.req = 2'b00;
    repeat (4) nclk();
    chk("s1_rises", rises, 8);
    chk("s1_byte", get_byte(0), 8'h41);
    chk("s1_ss3_low", low_last, 34);
    chk("s1_done0", done0, 1);
    chk("s1_byte_rd", brd0 + brd1, 0);
    chk("s1_di_setup", di_bad, 0);
    chk("s1_done_vs_ss3", done_bad, 0);

    // 0x22 with 256 incrementing payload bytes
    start_scn();
    bus.r1_cmd = 8'h22; bus.r1_len = 9'd256; bus.req = 2'b10;
    wait_dones(1, 9000, "s2_done");
    bus.req = 2'b00;
    repeat (4) nclk();
    chk("s2_rises", rises, 2056);
    chk("s2_ss3_low", low_last, 8226);
    chk("s2_byte_rd1", brd1, 256);
    chk("s2_byte_rd0", brd0, 0);
    chk("s2_cmd", get_byte(0), 8'h22);
    errs_d = 0; errs_t = 0;
    for (int b = 1; b <= 256; b++) begin
      if (get_byte(b) !== 8'(b - 1)) errs_d++;
      if (b > brd_off.size()) errs_t++;
      else if (brd_off[b - 1] != 16 * CD * b) errs_t++;
    end
    chk("s2_payload", errs_d, 0);
    chk("s2_byte_rd_timing", errs_t, 0);
    chk("s2_di_setup", di_bad, 0);
    chk("s2_done1", done1, 1);

    // length above 256 behaves as 256
    start_scn();
    bus.r1_cmd = 8'h23; bus.r1_len = 9'h1FF; bus.req = 2'b10;
    wait_dones(1, 9000, "s2b_done");
    bus.req = 2'b00;
    repeat (4) nclk();
    chk("s2b_rises", rises, 2056);
    chk("s2b_ss3_low", low_last, 8226);
    chk("s2b_byte_rd1", brd1, 256);

    // both requesting from reset
    start_scn();
    bus.r0_cmd = 8'h21; bus.r1_cmd = 8'h22; bus.r0_len = 9'd0; bus.r1_len = 9'd0;
    bus.req = 2'b11;
    wait_dones(2, 400, "s3_done");
    bus.req = 2'b00;
    repeat (4) nclk();
    chk("s3_first", (order.size() > 0) ? order[0] : 9, 0);
    chk("s3_second", (order.size() > 1) ? order[1] : 9, 1);
    chk("s3_byte0", get_byte(0), 8'h21);
    chk("s3_byte1", get_byte(1), 8'h22);
    chk("s3_gap_ge3", (min_high >= 3) ? 1 : 0, 1);
    chk("s3_gnt_onehot", gnt_both, 0);

    // requests held for four transactions
    start_scn();
    bus.req = 2'b11;
    wait_dones(4, 800, "s4_done");
    bus.req = 2'b00;
    repeat (4) nclk();
    for (int i = 0; i < 4; i++)
      chk($sformatf("s4_order%0d", i), (order.size() > i) ? order[i] : 9, i % 2);
    chk("s4_gnt_onehot", gnt_both, 0);

    // reset at the 4th SCK rise of a one-byte transaction
    start_scn();
    bus.r0_cmd = 8'h41; bus.r0_len = 9'd1; bus.req = 2'b01;
    k = 0;
    while (rises < 4 && k < 200) begin nclk(); k++; end
    chk("s5_reach_rise4", rises, 4);
    reset = 1'b1; bus.req = 2'b00;
    nclk();
    chk("s5_ss3", ss3, 1);
    chk("s5_sck", sck, 0);
    chk("s5_gnt", bus.gnt, 0);
    chk("s5_busy", busy, 0);
    reset = 1'b0;
    repeat (10) nclk();
    chk("s5_no_done", done0 + done1, 0);
    chk("s5_no_byte_rd", brd0 + brd1, 0);

`ifdef OSD_SCHED_ENSHADOW_EN
    // enable shadow: repeated 0x41 is skipped, 0x40 goes out
    start_scn();
    bus.r0_cmd = 8'h41; bus.r0_len = 9'd0; bus.req = 2'b01;
    wait_dones(1, 200, "s7_done1");
    bus.req = 2'b00;
    repeat (4) nclk();
    chk("s7_en_set", osd_en_state, 1);
    chk("s7_rises1", rises, 8);
    bus.req = 2'b01;
    wait_dones(2, 200, "s7_done2");
    bus.req = 2'b00;
    repeat (4) nclk();
    chk("s7_skip_rises", rises, 8);
    chk("s7_skip_falls", falls, 1);
    chk("s7_skip_latency", d_cyc - g_cyc, 1);
    chk("s7_en_kept", osd_en_state, 1);
    bus.r0_cmd = 8'h40; bus.req = 2'b01;
    wait_dones(3, 200, "s7_done3");
    bus.req = 2'b00;
    repeat (4) nclk();
    chk("s7_rises3", rises, 16);
    chk("s7_byte3", get_byte(1), 8'h40);
    chk("s7_en_clear", osd_en_state, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
